// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: owns the single-ported, fixed-latency main memory and shares it
// between I-cache block fills, D-cache block fills and D-cache write-through stores.
// Also produces the fetch/memory stage stall lines seen by the hazard unit.
// Optional build macro ARB_ROUND_ROBIN_EN: competing I/D fills alternate instead of
// D always winning; stores keep top priority either way.
module mem_fill_arbiter #(
   parameter int WORDS_PER_BLOCK = 8,
   parameter int IDX_W           = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_miss,
   input  logic [15:0]      i_miss_addr,
   input  logic             d_miss,
   input  logic [15:0]      d_miss_addr,
   input  logic             d_wr,
   input  logic [15:0]      d_wr_addr,
   input  logic [15:0]      d_wr_data,
   output logic             mem_en,
   output logic             mem_wr,
   output logic [15:0]      mem_addr,
   output logic [15:0]      mem_wdata,
   input  logic [15:0]      mem_rdata,
   input  logic             mem_rvalid,
   output logic             fill_we_i,
   output logic             fill_we_d,
   output logic [IDX_W-1:0] fill_word_idx,
   output logic [15:0]      fill_data,
   output logic             tag_we_i,
   output logic             tag_we_d,
   output logic             d_wr_ack,
   output logic             stall_fetch,
   output logic             stall_mem
);

   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);
   localparam logic [15:0]      OFF_MASK = 16'(2 * WORDS_PER_BLOCK - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WRITE  = 2'd1;
   localparam logic [1:0] ST_FILL_I = 2'd2;
   localparam logic [1:0] ST_FILL_D = 2'd3;

   logic [1:0]       state;
   logic [CNT_W-1:0] issue_cnt;
   logic [CNT_W-1:0] recv_cnt;
   logic [15:0]      base_addr;
   logic             grant_wr;
   logic             grant_d;
   logic             grant_i;
   logic             in_fill;
   logic             last_word;

`ifdef ARB_ROUND_ROBIN_EN
   logic             last_grant_d;

   // Remember which cache won the most recent fill so a tie goes the other way next time.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_d <= 1'b0;
      end else if (state == ST_IDLE && !grant_wr && (grant_d || grant_i)) begin
         last_grant_d <= grant_d;
      end
   end
`endif

   // Pick the next operation while idle; stores always go first since the pipe waits on them.
   always_comb begin
      grant_wr = 1'b0;
      grant_d  = 1'b0;
      grant_i  = 1'b0;
      if (d_wr) begin
         grant_wr = 1'b1;
      end else if (d_miss && i_miss) begin
`ifdef ARB_ROUND_ROBIN_EN
         if (last_grant_d) begin
            grant_i = 1'b1;
         end else begin
            grant_d = 1'b1;
         end
`else
         grant_d = 1'b1;
`endif
      end else if (d_miss) begin
         grant_d = 1'b1;
      end else if (i_miss) begin
         grant_i = 1'b1;
      end
   end

   assign in_fill   = (state == ST_FILL_I) || (state == ST_FILL_D);
   assign last_word = mem_rvalid && (recv_cnt == CNT_LAST);

   // Main sequencer: latch the block base on a fill grant, count issued and returned words.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         issue_cnt <= '0;
         recv_cnt  <= '0;
         base_addr <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               issue_cnt <= '0;
               recv_cnt  <= '0;
               if (grant_wr) begin
                  state <= ST_WRITE;
               end else if (grant_d) begin
                  state     <= ST_FILL_D;
                  base_addr <= d_miss_addr & ~OFF_MASK;
               end else if (grant_i) begin
                  state     <= ST_FILL_I;
                  base_addr <= i_miss_addr & ~OFF_MASK;
               end
            end
            ST_WRITE: begin
               state <= ST_IDLE;
            end
            ST_FILL_I, ST_FILL_D: begin
               if (issue_cnt != CNT_FULL) begin
                  issue_cnt <= issue_cnt + 1'b1;
               end
               if (mem_rvalid) begin
                  if (last_word) begin
                     state     <= ST_IDLE;
                     issue_cnt <= '0;
                     recv_cnt  <= '0;
                  end else begin
                     recv_cnt <= recv_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Memory port drive: a single store beat in WRITE, then back-to-back block reads while filling.
   always_comb begin
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = 16'h0000;
      mem_wdata = 16'h0000;
      d_wr_ack  = 1'b0;
      case (state)
         ST_WRITE: begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = d_wr_addr;
            mem_wdata = d_wr_data;
            d_wr_ack  = 1'b1;
         end
         ST_FILL_I, ST_FILL_D: begin
            if (issue_cnt != CNT_FULL) begin
               mem_en   = 1'b1;
               mem_addr = base_addr + 16'({issue_cnt, 1'b0});
            end
         end
         default: begin
         end
      endcase
   end

   assign fill_we_i     = (state == ST_FILL_I) && mem_rvalid;
   assign fill_we_d     = (state == ST_FILL_D) && mem_rvalid;
   assign tag_we_i      = (state == ST_FILL_I) && last_word;
   assign tag_we_d      = (state == ST_FILL_D) && last_word;
   assign fill_word_idx = recv_cnt[IDX_W-1:0];
   assign fill_data     = mem_rdata;

   assign stall_fetch = i_miss || (state == ST_FILL_I);
   assign stall_mem   = d_miss || (d_wr && !d_wr_ack) || (in_fill && state == ST_FILL_D);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb_mem_fill_arbiter: randomized and directed requests against a fixed-latency memory
// model; an operation-level reference model predicts every memory beat, fill write and
// tag write with its exact cycle, and a negedge monitor scores the DUT against it.
module tb_mem_fill_arbiter;

   localparam int WPB = 8;
   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_miss = 1'b0;
   logic [15:0] i_miss_addr = 16'h0;
   logic        d_miss = 1'b0;
   logic [15:0] d_miss_addr = 16'h0;
   logic        d_wr = 1'b0;
   logic [15:0] d_wr_addr = 16'h0;
   logic [15:0] d_wr_data = 16'h0;
   logic        mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_rvalid;
   logic        fill_we_i, fill_we_d;
   logic [2:0]  fill_word_idx;
   logic [15:0] fill_data;
   logic        tag_we_i, tag_we_d, d_wr_ack, stall_fetch, stall_mem;

   int cyc = 0;
   int vec_cnt = 0;
   int err_cnt = 0;

   typedef struct { int cyc; logic [15:0] addr; logic [15:0] data; } beat_t;
   typedef struct { int cyc; logic [1:0] we; logic [1:0] tag; logic [2:0] idx; logic [15:0] data; } fill_t;
   typedef struct { int first; int last; bit is_d; } span_t;

   beat_t rd_q[$];
   beat_t wr_q[$];
   fill_t fill_q[$];
   span_t span_q[$];
   int    wr_cyc = -1;
   logic [15:0] ref_mem [0:32767];
`ifdef ARB_ROUND_ROBIN_EN
   bit    model_last_d = 1'b0;
`endif

   mem_fill_arbiter #(.WORDS_PER_BLOCK(WPB), .IDX_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_miss(i_miss), .i_miss_addr(i_miss_addr),
      .d_miss(d_miss), .d_miss_addr(d_miss_addr),
      .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .fill_we_i(fill_we_i), .fill_we_d(fill_we_d), .fill_word_idx(fill_word_idx),
      .fill_data(fill_data), .tag_we_i(tag_we_i), .tag_we_d(tag_we_d),
      .d_wr_ack(d_wr_ack), .stall_fetch(stall_fetch), .stall_mem(stall_mem)
   );

   // Free-running clock and cycle number used to timestamp every expected event.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] init_word(input int a);
      return 16'(a * 40503) ^ 16'h5A5A;
   endfunction

   // Memory model: fixed read latency LAT, in-order returns, contents reloaded on reset.
   logic [15:0] mem_arr [0:32767];
   logic [LAT-1:0] pipe_v = '0;
   logic [15:0] pipe_d [0:LAT-1];
   logic spur = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         pipe_v <= '0;
         for (int a = 0; a < 32768; a++) mem_arr[a] <= init_word(a);
      end else begin
         pipe_v   <= {pipe_v[LAT-2:0], mem_en && !mem_wr};
         pipe_d[0] <= mem_arr[mem_addr[15:1]];
         for (int k = 1; k < LAT; k++) pipe_d[k] <= pipe_d[k-1];
         if (mem_en && mem_wr) mem_arr[mem_addr[15:1]] <= mem_wdata;
      end
   end

   assign mem_rvalid = pipe_v[LAT-1] | spur;
   assign mem_rdata  = pipe_d[LAT-1];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every DUT memory beat, fill write or tag write must match the queue head.
   always @(negedge clk) begin : monitor
      beat_t b;
      fill_t f;
      if (mem_en === 1'b1 && mem_wr === 1'b0) begin
         if (rd_q.size() == 0) checkOutput("rd_extra", 32'd1, 32'd0);
         else begin
            b = rd_q.pop_front();
            checkOutput("rd_addr", {16'h0, mem_addr}, {16'h0, b.addr});
            checkOutput("rd_cycle", cyc, b.cyc);
         end
      end
      if (d_wr_ack === 1'b1 || (mem_en === 1'b1 && mem_wr === 1'b1)) begin
         if (wr_q.size() == 0) checkOutput("wr_extra", 32'd1, 32'd0);
         else begin
            b = wr_q.pop_front();
            checkOutput("wr_strobes", {29'h0, mem_en, mem_wr, d_wr_ack}, 32'd7);
            checkOutput("wr_addr", {16'h0, mem_addr}, {16'h0, b.addr});
            checkOutput("wr_data", {16'h0, mem_wdata}, {16'h0, b.data});
            checkOutput("wr_cycle", cyc, b.cyc);
         end
      end
      if ((fill_we_i | fill_we_d | tag_we_i | tag_we_d) === 1'b1) begin
         if (fill_q.size() == 0) checkOutput("fill_extra", 32'd1, 32'd0);
         else begin
            f = fill_q.pop_front();
            checkOutput("fill_we", {30'h0, fill_we_d, fill_we_i}, {30'h0, f.we});
            checkOutput("tag_we", {30'h0, tag_we_d, tag_we_i}, {30'h0, f.tag});
            checkOutput("fill_idx", {29'h0, fill_word_idx}, {29'h0, f.idx});
            checkOutput("fill_data", {16'h0, fill_data}, {16'h0, f.data});
            checkOutput("fill_cycle", cyc, f.cyc);
         end
      end
   end

   // Reference model: walk the idle decision points and lay out each granted operation in time.
   task automatic modelRound(input bit has_wr, input bit has_d, input bit has_i,
                             input int arr_w, input int arr_d, input int arr_i,
                             input int n_d, input int n_i);
      int g = 0;
      int left_w, left_d, left_i, guard;
      bit pw, pd, pi, take_d;
      logic [15:0] base, a;
      beat_t b;
      fill_t f;
      span_t s;
      g = arr_w < arr_d ? arr_w : arr_d;
      g = 0;
      left_w = has_wr ? 1 : 0;
      left_d = has_d ? n_d : 0;
      left_i = has_i ? n_i : 0;
      guard  = 0;
      wr_cyc = -1;
      g = cyc;
      while ((left_w + left_d + left_i) > 0 && guard < 1000) begin
         guard++;
         pw = (left_w > 0) && (arr_w <= g);
         pd = (left_d > 0) && (arr_d <= g);
         pi = (left_i > 0) && (arr_i <= g);
         if (pw) begin
            b.cyc = g + 1; b.addr = d_wr_addr; b.data = d_wr_data;
            wr_q.push_back(b);
            ref_mem[d_wr_addr[15:1]] = d_wr_data;
            wr_cyc = g + 1;
            left_w--;
            g += 2;
         end else if (pd || pi) begin
`ifdef ARB_ROUND_ROBIN_EN
            take_d = pd && (!pi || !model_last_d);
            model_last_d = take_d;
`else
            take_d = pd;
`endif
            base = (take_d ? d_miss_addr : i_miss_addr) & ~16'(2 * WPB - 1);
            for (int k = 0; k < WPB; k++) begin
               a = base + 16'(2 * k);
               b.cyc = g + 1 + k; b.addr = a; b.data = 16'h0;
               rd_q.push_back(b);
               f.cyc  = g + 1 + k + LAT;
               f.we   = take_d ? 2'b10 : 2'b01;
               f.tag  = (k == WPB - 1) ? f.we : 2'b00;
               f.idx  = 3'(k);
               f.data = ref_mem[a[15:1]];
               fill_q.push_back(f);
            end
            s.first = g + 1; s.last = g + WPB + LAT; s.is_d = take_d;
            span_q.push_back(s);
            if (take_d) left_d--; else left_i--;
            g += WPB + LAT + 1;
         end else begin
            g++;
         end
      end
   endtask

   // One-cycle synchronous reset; requesters withdraw and the model forgets everything in flight.
   task automatic doReset();
      rst_n = 1'b0; d_wr = 1'b0; d_miss = 1'b0; i_miss = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      rd_q.delete(); wr_q.delete(); fill_q.delete(); span_q.delete();
      wr_cyc = -1;
      for (int a = 0; a < 32768; a++) ref_mem[a] = init_word(a);
`ifdef ARB_ROUND_ROBIN_EN
      model_last_d = 1'b0;
`endif
   endtask

   // Run one round of requests (arrival offsets relative to round start) to completion.
   task automatic applyStimulus(input bit has_wr, input bit has_d, input bit has_i,
                                input int off_w, input int off_d, input int off_i,
                                input int n_d, input int n_i,
                                input logic [15:0] wa, input logic [15:0] wd,
                                input logic [15:0] da, input logic [15:0] ia);
      int c0, budget, done_d, done_i;
      bit done_w, saw_ack, saw_td, saw_ti, in_i, in_d, complete;
      @(posedge clk); #1;
      c0 = cyc;
      d_wr_addr = wa; d_wr_data = wd; d_miss_addr = da; i_miss_addr = ia;
      span_q.delete();
      modelRound(has_wr, has_d, has_i, c0 + off_w, c0 + off_d, c0 + off_i, n_d, n_i);
      budget = 0; done_d = 0; done_i = 0; done_w = 1'b0;
      saw_ack = 1'b0; saw_td = 1'b0; saw_ti = 1'b0;
      while (1) begin
         if (saw_ack) begin d_wr = 1'b0; done_w = 1'b1; end
         if (saw_td) begin done_d++; if (done_d == n_d) d_miss = 1'b0; end
         if (saw_ti) begin done_i++; if (done_i == n_i) i_miss = 1'b0; end
         if (has_wr && cyc == c0 + off_w) d_wr = 1'b1;
         if (has_d && cyc == c0 + off_d) d_miss = 1'b1;
         if (has_i && cyc == c0 + off_i) i_miss = 1'b1;
         complete = (!has_wr || done_w) && (!has_d || done_d >= n_d) && (!has_i || done_i >= n_i);
         @(negedge clk);
         in_i = 1'b0; in_d = 1'b0;
         foreach (span_q[j]) begin
            if (cyc >= span_q[j].first && cyc <= span_q[j].last) begin
               if (span_q[j].is_d) in_d = 1'b1; else in_i = 1'b1;
            end
         end
         checkOutput("stall_fetch", {31'h0, stall_fetch}, {31'h0, i_miss | in_i});
         checkOutput("stall_mem", {31'h0, stall_mem}, {31'h0, d_miss | (d_wr & (cyc != wr_cyc)) | in_d});
         saw_ack = d_wr_ack; saw_td = tag_we_d; saw_ti = tag_we_i;
         if (complete) break;
         if (budget >= 400) begin
            checkOutput("round_timeout", 32'd1, 32'd0);
            @(posedge clk); #1;
            doReset();
            break;
         end
         @(posedge clk); #1;
         budget++;
      end
      repeat (2) @(posedge clk);
      checkOutput("rd_left", rd_q.size(), 32'd0);
      checkOutput("wr_left", wr_q.size(), 32'd0);
      checkOutput("fill_left", fill_q.size(), 32'd0);
   endtask

   // Safety net so a wedged run still ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Test sequence: reset state, directed scenarios, mid-fill reset, spurious return, random rounds.
   initial begin
      bit hw, hd, hi;
      for (int a = 0; a < 32768; a++) ref_mem[a] = init_word(a);
      repeat (2) @(posedge clk); #1;
      doReset();
      @(negedge clk);
      checkOutput("reset_strobes", {23'h0, mem_en, mem_wr, fill_we_i, fill_we_d, tag_we_i, tag_we_d,
                                    d_wr_ack, stall_fetch, stall_mem}, 32'd0);
      checkOutput("reset_addr", {16'h0, mem_addr}, 32'd0);
      checkOutput("reset_wdata", {16'h0, mem_wdata}, 32'd0);

      applyStimulus(0, 0, 1, 0, 0, 0, 1, 1, 16'h0, 16'h0, 16'h0, 16'h0046);
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 1, 16'h1234, 16'hBEEF, 16'h1234, 16'h0);
      applyStimulus(0, 1, 1, 0, 4, 0, 1, 1, 16'h0, 16'h0, 16'h0100, 16'h0040);
      applyStimulus(0, 1, 1, 0, 0, 0, 2, 2, 16'h0, 16'h0, 16'h2468, 16'h1357);

      // D fill interrupted by reset after five words, then a clean I fill.
      @(posedge clk); #1;
      d_miss_addr = 16'h3C5A;
      span_q.delete();
      modelRound(0, 1, 0, 0, cyc, 0, 1, 1);
      d_miss = 1'b1;
      repeat (5 + LAT) @(posedge clk);
      #1;
      doReset();
      @(negedge clk);
      checkOutput("post_reset_quiet", {27'h0, fill_we_i, fill_we_d, tag_we_i, tag_we_d, mem_en}, 32'd0);
      checkOutput("post_reset_stall", {30'h0, stall_fetch, stall_mem}, 32'd0);
      applyStimulus(0, 0, 1, 0, 0, 0, 1, 1, 16'h0, 16'h0, 16'h0, 16'h7FF2);

      // Stray read-valid while idle must not reach either cache.
      @(posedge clk); #1;
      spur = 1'b1;
      @(negedge clk);
      checkOutput("spurious_fill", {28'h0, fill_we_i, fill_we_d, tag_we_i, tag_we_d}, 32'd0);
      @(posedge clk); #1;
      spur = 1'b0;

      for (int r = 0; r < 40; r++) begin
         hw = 1'($urandom_range(0, 1));
         hd = 1'($urandom_range(0, 1));
         hi = 1'($urandom_range(0, 1));
         if (!hw && !hd && !hi) hi = 1'b1;
         applyStimulus(hw, hd, hi,
                       int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                       int'($urandom_range(1, 2)), int'($urandom_range(1, 2)),
                       16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
